// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the DMEM arbiter
package dmem_arb_pkg;

   localparam int DMEM_AW = 5;
   localparam int DMEM_DW = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CPU   = 2'd1,
      S_HOST  = 2'd2,
      S_HLOCK = 2'd3
   } owner_e;

   typedef enum logic {
      GNT_CPU  = 1'b0,
      GNT_HOST = 1'b1
   } gnt_e;

   // burst counter only needs to reach HOST_MAX_BURST-1
   function automatic int burst_cw(input int max_burst);
      return (max_burst > 1) ? $clog2(max_burst) : 1;
   endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - combinational grant decision; round robin on ties under DMEM_ARB_RR_EN,
// fixed CPU priority otherwise
module dmem_arb_grant
   import dmem_arb_pkg::*;
#(
   parameter int HOST_MAX_BURST = 4,
   parameter int BCW            = 2
) (
   input  logic           i_ena,
   input  logic           i_cpu_req,
   input  logic           i_host_req,
   input  owner_e         i_owner,
   input  logic [BCW-1:0] i_burst_cnt,
   input  gnt_e           i_last_gnt,
   output logic           o_cpu_gnt,
   output logic           o_host_gnt
);

   always_comb begin
      o_cpu_gnt  = 1'b0;
      o_host_gnt = 1'b0;
      if (i_ena) begin
         if (i_cpu_req && !i_host_req) begin
            o_cpu_gnt = 1'b1;
         end else if (i_host_req && !i_cpu_req) begin
            o_host_gnt = 1'b1;
         end else if (i_cpu_req && i_host_req) begin
            if (i_owner == S_HLOCK && int'(i_burst_cnt) < HOST_MAX_BURST - 1) begin
               o_host_gnt = 1'b1;
            end else begin
`ifdef DMEM_ARB_RR_EN
               if (i_last_gnt == GNT_CPU) o_host_gnt = 1'b1;
               else                       o_cpu_gnt  = 1'b1;
`else
               o_cpu_gnt = 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host arbiter for the single-port DMEM (DMEM_ARB_RR_EN selects round robin)
// Holds ownership state, data muxes, host read register and saturating CPU stall counter.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW             = DMEM_AW,
   parameter int DW             = DMEM_DW,
   parameter int HOST_MAX_BURST = 4,
   parameter int STALL_CW       = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_ena,
   input  logic                i_cpu_req,
   input  logic                i_cpu_worr,
   input  logic [AW-1:0]       i_cpu_addr,
   input  logic [DW-1:0]       i_cpu_wdata,
   output logic [DW-1:0]       o_cpu_rdata,
   output logic                o_cpu_stall,
   input  logic                i_host_req,
   input  logic                i_host_worr,
   input  logic                i_host_lock,
   input  logic [AW-1:0]       i_host_addr,
   input  logic [DW-1:0]       i_host_wdata,
   output logic                o_host_gnt,
   output logic                o_host_rvalid,
   output logic [DW-1:0]       o_host_rdata,
   output logic                o_mem_ena,
   output logic                o_mem_worr,
   output logic [AW-1:0]       o_mem_addr,
   output logic [DW-1:0]       o_mem_wdata,
   input  logic [DW-1:0]       i_mem_rdata,
   output logic [STALL_CW-1:0] o_stall_cnt
);

   localparam int BCW = burst_cw(HOST_MAX_BURST);

   owner_e                r_owner;
   gnt_e                  r_last_gnt;
   logic [BCW-1:0]        r_burst_cnt;
   logic                  r_host_rvalid;
   logic [DW-1:0]         r_host_rdata;
   logic [STALL_CW-1:0]   r_stall_cnt;
   logic                  w_ena;
   logic                  w_cpu_gnt;
   logic                  w_host_gnt;
   logic                  w_cpu_stall;

   // gating with reset keeps DMEM untouched while reset is held
   assign w_ena = i_ena & i_rst;

   dmem_arb_grant #(
      .HOST_MAX_BURST (HOST_MAX_BURST),
      .BCW            (BCW)
   ) u_grant (
      .i_ena       (w_ena),
      .i_cpu_req   (i_cpu_req),
      .i_host_req  (i_host_req),
      .i_owner     (r_owner),
      .i_burst_cnt (r_burst_cnt),
      .i_last_gnt  (r_last_gnt),
      .o_cpu_gnt   (w_cpu_gnt),
      .o_host_gnt  (w_host_gnt)
   );

   assign w_cpu_stall   = w_ena & i_cpu_req & ~w_cpu_gnt;
   assign o_cpu_stall   = w_cpu_stall;
   assign o_cpu_rdata   = w_cpu_gnt ? i_mem_rdata : '0;
   assign o_host_gnt    = w_host_gnt;
   assign o_host_rvalid = r_host_rvalid;
   assign o_host_rdata  = r_host_rdata;
   assign o_stall_cnt   = r_stall_cnt;

   always_comb begin
      o_mem_ena   = w_cpu_gnt | w_host_gnt;
      o_mem_worr  = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_cpu_gnt) begin
         o_mem_worr  = i_cpu_worr;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
      end else if (w_host_gnt) begin
         o_mem_worr  = i_host_worr;
         o_mem_addr  = i_host_addr;
         o_mem_wdata = i_host_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_owner       <= S_IDLE;
         r_last_gnt    <= GNT_HOST;
         r_burst_cnt   <= '0;
         r_host_rvalid <= 1'b0;
         r_host_rdata  <= '0;
         r_stall_cnt   <= '0;
      end else if (i_ena) begin
         if (w_host_gnt) begin
            r_last_gnt <= GNT_HOST;
            if (i_host_lock) begin
               r_owner <= S_HLOCK;
               // the bound only counts beats taken while the CPU is waiting
               if (i_cpu_req) r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
               r_owner     <= S_HOST;
               r_burst_cnt <= '0;
            end
         end else if (w_cpu_gnt) begin
            r_last_gnt  <= GNT_CPU;
            r_owner     <= S_CPU;
            r_burst_cnt <= '0;
         end else begin
            r_owner     <= S_IDLE;
            r_burst_cnt <= '0;
         end
         r_host_rvalid <= w_host_gnt & ~i_host_worr;
         if (w_host_gnt && !i_host_worr) r_host_rdata <= i_mem_rdata;
         if (w_cpu_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (follows DMEM_ARB_RR_EN if defined)
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        cpu_req, cpu_worr;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        host_req, host_worr, host_lock;
   logic [4:0]  host_addr;
   logic [31:0] host_wdata;
   logic        host_gnt, host_rvalid;
   logic [31:0] host_rdata;
   logic        mem_ena, mem_worr;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;

   logic [31:0] d2_cpu_rdata, d2_host_rdata, d2_mem_wdata;
   logic        d2_cpu_stall, d2_host_gnt, d2_host_rvalid, d2_mem_ena, d2_mem_worr;
   logic [4:0]  d2_mem_addr;
   logic [3:0]  d2_stall_cnt;

   logic [31:0] mem [32];
   logic [31:0] sb [$];
   int          tests = 0;
   int          fails = 0;
   int          exp_stall = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_ena && mem_worr) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   dmem_arbiter #(.AW(5), .DW(32), .HOST_MAX_BURST(4), .STALL_CW(16)) u_dut (
      .i_clk(clk), .i_rst(rst_n), .i_ena(ena),
      .i_cpu_req(cpu_req), .i_cpu_worr(cpu_worr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
      .i_host_req(host_req), .i_host_worr(host_worr), .i_host_lock(host_lock),
      .i_host_addr(host_addr), .i_host_wdata(host_wdata),
      .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
      .o_mem_ena(mem_ena), .o_mem_worr(mem_worr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_stall_cnt(stall_cnt)
   );

   dmem_arbiter #(.AW(5), .DW(32), .HOST_MAX_BURST(4), .STALL_CW(4)) u_dut_sat (
      .i_clk(clk), .i_rst(rst_n), .i_ena(ena),
      .i_cpu_req(cpu_req), .i_cpu_worr(cpu_worr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_rdata(d2_cpu_rdata), .o_cpu_stall(d2_cpu_stall),
      .i_host_req(host_req), .i_host_worr(host_worr), .i_host_lock(host_lock),
      .i_host_addr(host_addr), .i_host_wdata(host_wdata),
      .o_host_gnt(d2_host_gnt), .o_host_rvalid(d2_host_rvalid), .o_host_rdata(d2_host_rdata),
      .o_mem_ena(d2_mem_ena), .o_mem_worr(d2_mem_worr), .o_mem_addr(d2_mem_addr),
      .o_mem_wdata(d2_mem_wdata), .i_mem_rdata(32'h0), .o_stall_cnt(d2_stall_cnt)
   );

   // scoreboard consumer: every rvalid must match the oldest expected host read
   always @(negedge clk) begin
      if (rst_n && host_rvalid) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_rvalid: got rdata %h, expected no rvalid", host_rdata);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            if (host_rdata !== e) begin
               fails++;
               $display("FAIL sb_host_rdata: got %h expected %h", host_rdata, e);
            end
         end
      end
   end

   task automatic idle_inputs();
      cpu_req = 0; cpu_worr = 0; cpu_addr = 0; cpu_wdata = 0;
      host_req = 0; host_worr = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (host_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b expected 0", host_rvalid); end
      tests++; if (host_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h expected 0", host_rdata); end
      tests++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
      tests++; if (mem_ena !== 1'b0) begin fails++; $display("FAIL rst_mem_ena: got %b expected 0", mem_ena); end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_cpu_only();
      cpu_req = 1; cpu_worr = 1; cpu_addr = 3; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpu_sw_stall: got %b expected 0", cpu_stall); end
      tests++; if ({mem_ena, mem_worr, mem_addr} !== {2'b11, 5'd3}) begin
         fails++; $display("FAIL cpu_sw_mem: got %b%b %0d expected 11 3", mem_ena, mem_worr, mem_addr);
      end
      @(posedge clk); #1;
      cpu_worr = 0;
      @(negedge clk);
      tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpu_lw_stall: got %b expected 0", cpu_stall); end
      tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL cpu_lw_rdata: got %h expected deadbeef", cpu_rdata); end
      @(posedge clk); #1;
      ena = 0; host_req = 1; host_addr = 3;
      @(negedge clk);
      tests++; if ({mem_ena, host_gnt, cpu_stall, cpu_rdata} !== 35'h0) begin
         fails++; $display("FAIL ena_low: got mem_ena %b gnt %b stall %b rdata %h expected all 0",
                           mem_ena, host_gnt, cpu_stall, cpu_rdata);
      end
      @(posedge clk); #1;
      ena = 1; idle_inputs();
      tests++; if (stall_cnt !== 16'(exp_stall)) begin fails++; $display("FAIL cpu_only_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_host_read();
      host_req = 1; host_worr = 0; host_addr = 3;
      sb.push_back(32'hDEADBEEF);
      @(negedge clk);
      tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL host_rd_gnt: got %b expected 1", host_gnt); end
      @(posedge clk); #1;
      host_req = 0;
      tests++; if (host_rvalid !== 1'b1) begin fails++; $display("FAIL host_rd_rvalid: got %b expected 1", host_rvalid); end
      @(posedge clk); #1;
      tests++; if (host_rvalid !== 1'b0) begin fails++; $display("FAIL host_rd_rvalid_pulse: got %b expected 0", host_rvalid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [2];
      vals[0] = 32'h11111111; vals[1] = 32'h22222222;
      for (int i = 0; i < 4; i++) begin
         host_req = 1; host_worr = (i < 2); host_addr = 5'(5 + i % 2); host_wdata = vals[i % 2];
         if (i >= 2) sb.push_back(vals[i % 2]);
         @(negedge clk);
         tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt%0d: got %b expected 1", i, host_gnt); end
         @(posedge clk); #1;
         if (i >= 2) begin
            tests++; if (host_rvalid !== 1'b1) begin fails++; $display("FAIL b2b_rvalid%0d: got %b expected 1", i, host_rvalid); end
         end
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      cpu_req = 1; cpu_worr = 0; cpu_addr = 3;
      host_req = 1; host_worr = 0; host_addr = 5; host_lock = 0;
      for (int i = 0; i < 4; i++) begin
         bit exp_h;
         exp_h = RR_EN && (i % 2 == 1);
         if (exp_h) begin sb.push_back(32'h11111111); exp_stall++; end
         @(negedge clk);
         tests++; if (host_gnt !== exp_h || cpu_stall !== exp_h) begin
            fails++; $display("FAIL tie%0d: got host_gnt %b stall %b expected %b", i, host_gnt, cpu_stall, exp_h);
         end
         if (!exp_h) begin
            tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL tie%0d_rdata: got %h expected deadbeef", i, cpu_rdata); end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;
      tests++; if (stall_cnt !== 16'(exp_stall)) begin fails++; $display("FAIL tie_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_locked_burst();
      host_req = 1; host_worr = 0; host_addr = 6; host_lock = 1;
      cpu_worr = 0; cpu_addr = 3;
      for (int i = 0; i < 5; i++) begin
         bit exp_h, exp_s;
         cpu_req = (i != 0);
         exp_h = (i < 4);
         exp_s = cpu_req && exp_h;
         if (exp_h) sb.push_back(32'h22222222);
         if (exp_s) exp_stall++;
         @(negedge clk);
         tests++; if (host_gnt !== exp_h || cpu_stall !== exp_s) begin
            fails++; $display("FAIL burst%0d: got host_gnt %b stall %b expected %b %b", i, host_gnt, cpu_stall, exp_h, exp_s);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;
      tests++; if (stall_cnt !== 16'(exp_stall)) begin fails++; $display("FAIL burst_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_reset_mid_burst();
      host_req = 1; host_worr = 0; host_addr = 5; host_lock = 1;
      @(negedge clk);
      tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL rmb_gnt: got %b expected 1", host_gnt); end
      @(posedge clk); #1;
      tests++; if (host_rvalid !== 1'b1) begin fails++; $display("FAIL rmb_rvalid_pre: got %b expected 1", host_rvalid); end
      #1 rst_n = 0;
      exp_stall = 0;
      #1;
      tests++; if ({host_rvalid, host_rdata, stall_cnt} !== 49'h0) begin
         fails++; $display("FAIL rmb_async: got rvalid %b rdata %h stall %0d expected 0 0 0", host_rvalid, host_rdata, stall_cnt);
      end
      host_worr = 1; host_lock = 0; host_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      tests++; if (mem_ena !== 1'b0) begin fails++; $display("FAIL rmb_mem_ena: got %b expected 0", mem_ena); end
      @(posedge clk); #1;
      tests++; if (mem[5] !== 32'h11111111) begin fails++; $display("FAIL rmb_no_write: got %h expected 11111111", mem[5]); end
      rst_n = 1;
      cpu_req = 1; cpu_worr = 0; cpu_addr = 3; host_worr = 0;
      @(negedge clk);
      tests++; if (host_gnt !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL rmb_tie: got host_gnt %b stall %b rdata %h expected 0 0 deadbeef", host_gnt, cpu_stall, cpu_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_stall_saturate();
      for (int it = 0; it < 7; it++) begin
         for (int c = 0; c < 5; c++) begin
            host_req = 1; host_worr = 1; host_addr = 7; host_wdata = 32'(it);
            host_lock = (c != 0);
            cpu_req = (c >= 2); cpu_worr = 0; cpu_addr = 3;
            if (c >= 2) exp_stall++;
            @(negedge clk);
            tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL sat_gnt%0d_%0d: got %b expected 1", it, c, host_gnt); end
            @(posedge clk); #1;
         end
         if (it == 4) begin
            tests++; if (d2_stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_at15: got %0d expected 15", d2_stall_cnt); end
         end
      end
      idle_inputs();
      tests++; if (d2_stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d expected 15", d2_stall_cnt); end
      tests++; if (stall_cnt !== 16'(exp_stall)) begin fails++; $display("FAIL sat_wide_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 0; ena = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_cpu_only();
      test_host_read();
      test_back_to_back();
      test_contention();
      test_locked_burst();
      test_reset_mid_burst();
      test_stall_saturate();
      @(posedge clk); #1;
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
